// File: rtl/alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// alu_cmd_ctrl
//
// Purpose
//   Turns a byte-serial command stream into one ALU operation and sends the
//   result back as a single response byte. A command frame is four bytes:
//   0xCC (sync), A, B, FUN. Only FUN[3:0] selects the ALU function.
//
//   Sequence: IDLE -> GET_A -> GET_B -> GET_FUN -> ISSUE -> WAIT_RES -> SEND
//   -> IDLE. ISSUE is one cycle with alu_en=1. WAIT_RES captures the first
//   alu_out qualified by out_valid. SEND offers the result until the
//   transmitter accepts it.
//
// Handshakes
//   rx_valid : one-cycle strobe. Each high cycle delivers exactly one rx_data
//              byte. The byte is consumed only in IDLE, GET_A, GET_B and
//              GET_FUN. Bytes arriving in any other state are dropped.
//   out_valid: sampled only in WAIT_RES. The first high cycle there is the
//              result.
//   tx       : valid/ready, where ready = !tx_busy. tx_valid and tx_data stay
//              stable while tx_busy=1. A cycle with tx_valid=1 and tx_busy=0
//              is the single transfer. tx_valid drops on the next cycle.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous reset, active low
//   rx_data    in   [7:0]   received command byte
//   rx_valid   in           strobe qualifying rx_data
//   A, B       out  [dataWidth-1:0]  ALU operands (registered)
//   alu_fun    out  [3:0]   ALU function select (registered)
//   alu_en     out          one-cycle ALU enable, high only in ISSUE
//   alu_out    in   [dataWidth-1:0]  ALU result
//   out_valid  in           qualifies alu_out
//   tx_data    out  [7:0]   response byte (result register)
//   tx_valid   out          response byte offered
//   tx_busy    in           transmitter cannot accept a byte
//   err        out          one-cycle pulse on ALU timeout
//   fsm_state  out  [2:0]   current FSM state, for debug and checkers
//
// Build option
//   ALU_TIMEOUT_EN : when defined, WAIT_RES gives up after 16 cycles without
//   out_valid. It then loads 0xEE as the result, pulses err and sends the
//   byte. When not defined, WAIT_RES waits indefinitely and err is tied to 0.
// -----------------------------------------------------------------------------
module alu_cmd_ctrl #(
    parameter int dataWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [dataWidth-1:0] A,
    output logic [dataWidth-1:0] B,
    output logic [3:0]           alu_fun,
    output logic                 alu_en,
    input  logic [dataWidth-1:0] alu_out,
    input  logic                 out_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_busy,
    output logic                 err,
    output logic [2:0]           fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_A    = 3'd1,
        GET_B    = 3'd2,
        GET_FUN  = 3'd3,
        ISSUE    = 3'd4,
        WAIT_RES = 3'd5,
        SEND     = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hCC;

    state_t               state;
    logic [dataWidth-1:0] result_q;

`ifdef ALU_TIMEOUT_EN
    localparam logic [dataWidth-1:0] TIMEOUT_RESULT = 8'hEE;
    localparam logic [3:0]           TIMEOUT_LAST   = 4'hF;

    // Counts completed WAIT_RES cycles that had no out_valid. It holds 15
    // during the 16th cycle, so the timeout fires on that cycle's edge.
    logic [3:0] wait_cnt;
    logic       err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            A        <= '0;
            B        <= '0;
            alu_fun  <= '0;
            alu_en   <= 1'b0;
            result_q <= '0;
            tx_valid <= 1'b0;
`ifdef ALU_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low. Only the transition that needs a
            // pulse raises them for one cycle.
            alu_en <= 1'b0;
`ifdef ALU_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Wait for the sync byte. Any other byte is ignored.
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state <= GET_A;
                    end
                end

                // Inside a frame, 0xCC is ordinary data. It does not resync.
                GET_A: begin
                    if (rx_valid) begin
                        A     <= rx_data;
                        state <= GET_B;
                    end
                end

                GET_B: begin
                    if (rx_valid) begin
                        B     <= rx_data;
                        state <= GET_FUN;
                    end
                end

                GET_FUN: begin
                    if (rx_valid) begin
                        alu_fun <= rx_data[3:0];
                        // Registered alu_en is high exactly while in ISSUE.
                        alu_en  <= 1'b1;
                        state   <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Any out_valid seen during this cycle is ignored.
                    state <= WAIT_RES;
`ifdef ALU_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end

                WAIT_RES: begin
                    if (out_valid) begin
                        // A real result wins, even on the 16th cycle.
                        result_q <= alu_out;
                        tx_valid <= 1'b1;
                        state    <= SEND;
`ifdef ALU_TIMEOUT_EN
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        result_q <= TIMEOUT_RESULT;
                        tx_valid <= 1'b1;
                        err_q    <= 1'b1;
                        state    <= SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
`endif
                    end
                end

                SEND: begin
                    // The accepting cycle is the transfer. Drop valid next.
                    if (!tx_busy) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data   = result_q;
    assign fsm_state = state;

`ifdef ALU_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
module tb_alu_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] a_o, b_o;
  logic [3:0] alu_fun;
  logic       alu_en;
  logic [7:0] alu_out;
  logic       out_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic       err;
  logic [2:0] fsm_state;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues: expected ALU issue {A,B,fun} and expected tx bytes.
  logic [19:0] exp_alu_q[$];
  logic [7:0]  exp_tx_q[$];

  int alu_en_cnt = 0;
  int xfer_cnt   = 0;
  int err_cnt    = 0;

  // ALU model controls.
  int   alu_delay  = 1;
  logic alu_mute   = 1'b0;
  logic early_junk = 1'b0;

  alu_cmd_ctrl #(.dataWidth(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .A(a_o), .B(b_o), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .out_valid(out_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .err(err), .fsm_state(fsm_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Check helper.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0: alu_calc = a + b;
      4'd1: alu_calc = a - b;
      4'd2: alu_calc = a & b;
      4'd3: alu_calc = a | b;
      default: alu_calc = a ^ b;
    endcase
  endfunction

  // ALU model. It reacts to alu_en seen in ISSUE and answers alu_delay
  // cycles later in WAIT_RES. It can inject junk during ISSUE or stay mute.
  initial begin
    out_valid = 1'b0;
    alu_out   = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (alu_en) begin
        if (early_junk) begin
          out_valid = 1'b1;
          alu_out   = 8'h99;
        end
        if (!alu_mute) begin
          for (int i = 0; i < alu_delay; i++) begin
            @(posedge clk); #1;
            out_valid = 1'b0;
          end
          out_valid = 1'b1;
          alu_out   = alu_calc(a_o, b_o, alu_fun);
          @(posedge clk); #1;
          out_valid = 1'b0;
        end else begin
          @(posedge clk); #1;
          out_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each ALU issue and each tx transfer.
  initial begin
    logic [19:0] e_alu;
    logic [7:0]  e_tx;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (err) err_cnt++;
        if (alu_en) begin
          alu_en_cnt++;
          if (exp_alu_q.size() == 0) begin
            chk("unexpected_alu_en", {12'h0, a_o, b_o, alu_fun}, 32'hFFFFFFFF);
          end else begin
            e_alu = exp_alu_q.pop_front();
            chk("alu_issue", {12'h0, a_o, b_o, alu_fun}, {12'h0, e_alu});
          end
        end
        if (tx_valid && !tx_busy) begin
          xfer_cnt++;
          if (exp_tx_q.size() == 0) begin
            chk("unexpected_tx", {24'h0, tx_data}, 32'hFFFFFFFF);
          end else begin
            e_tx = exp_tx_q.pop_front();
            chk("tx_data", {24'h0, tx_data}, {24'h0, e_tx});
          end
        end
      end
    end
  end

  // Driver tasks. All are called just after a rising edge (#1).
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    send_byte(8'hCC);
    send_byte(a);
    send_byte(b);
    send_byte(f);
  endtask

  task automatic expect_frame(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f, input logic [7:0] res);
    exp_alu_q.push_back({a, b, f});
    exp_tx_q.push_back(res);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_xfer(input int limit);
    int start;
    bit done;
    start = xfer_cnt;
    done  = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(posedge clk); #1;
      if (xfer_cnt != start) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_xfer: no transfer within %0d cycles", limit);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    chk(name, {a_o, b_o, alu_fun, tx_data, tx_valid, alu_en, err, fsm_state},
        32'h0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    idle_cycles(n);
    check_zero_outputs("reset_outputs");
    rst = 1'b1;
    idle_cycles(1);
  endtask

  // Main stimulus.
  initial begin
    int lat;
    int en_before;
    int err_before;
    int x_before;
    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    // Basic add frame. Also checks the 3-cycle latency from the FUN strobe.
    expect_frame(8'h0A, 8'h02, 4'h0, 8'h0C);
    send_frame(8'h0A, 8'h02, 8'h00);
    lat = 1;
    while (!tx_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 3);
    wait_xfer(20);
    idle_cycles(1);
    chk("idle_after_tx", {fsm_state, tx_valid}, 4'h0);

    // The upper FUN nibble is ignored.
    expect_frame(8'h0A, 8'h02, 4'h3, 8'h0A);
    send_frame(8'h0A, 8'h02, 8'hF3);
    wait_xfer(20);

    // Stray bytes in IDLE, then one frame: exactly one alu_en.
    en_before = alu_en_cnt;
    send_byte(8'h55);
    send_byte(8'hAA);
    idle_cycles(2);
    expect_frame(8'h07, 8'h03, 4'h1, 8'h04);
    send_frame(8'h07, 8'h03, 8'h01);
    wait_xfer(20);
    chk("single_alu_en", alu_en_cnt - en_before, 1);

    // Back-pressure: busy for 5 SEND cycles, so data is stable for 6 cycles.
    tx_busy = 1'b1;
    expect_frame(8'h05, 8'h03, 4'h2, 8'h01);
    send_frame(8'h05, 8'h03, 8'h02);
    for (int i = 0; i < 20 && !tx_valid; i++) begin
      @(posedge clk); #1;
    end
    x_before = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("busy_hold", {tx_valid, tx_data}, {1'b1, 8'h01});
      // A 0xCC byte during SEND must be dropped.
      if (i == 2) send_byte(8'hCC); else begin @(posedge clk); #1; end
    end
    tx_busy = 1'b0;
    chk("busy_release", {tx_valid, tx_data}, {1'b1, 8'h01});
    @(posedge clk); #1;
    chk("post_xfer_idle", {fsm_state, tx_valid}, 4'h0);
    chk("busy_single_xfer", xfer_cnt - x_before, 1);

    // Reset after the B byte aborts the frame. A fresh frame then works.
    send_byte(8'hCC);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset(1);
    expect_frame(8'h11, 8'h22, 4'h0, 8'h33);
    send_frame(8'h11, 8'h22, 8'h00);
    wait_xfer(20);

    // Reset in the middle of SEND: no transfer happens.
    tx_busy = 1'b1;
    exp_alu_q.push_back({8'h40, 8'h01, 4'h0});
    send_frame(8'h40, 8'h01, 8'h00);
    idle_cycles(3);
    chk("send_pending", {fsm_state, tx_valid}, {3'd6, 1'b1});
    x_before = xfer_cnt;
    do_reset(1);
    tx_busy = 1'b0;
    idle_cycles(5);
    chk("no_xfer_after_abort", xfer_cnt - x_before, 0);

    // out_valid during ISSUE is ignored. The later real result is captured.
    early_junk = 1'b1;
    alu_delay  = 3;
    expect_frame(8'h09, 8'h04, 4'h0, 8'h0D);
    send_frame(8'h09, 8'h04, 8'h00);
    wait_xfer(20);
    early_junk = 1'b0;
    alu_delay  = 1;

    // 0xCC inside a frame is treated as data.
    expect_frame(8'hCC, 8'h01, 4'h0, 8'hCD);
    send_frame(8'hCC, 8'h01, 8'h00);
    wait_xfer(20);

`ifdef ALU_TIMEOUT_EN
    // A mute ALU leads to a timeout: err pulses once and 0xEE is sent.
    err_before = err_cnt;
    alu_mute = 1'b1;
    expect_frame(8'h01, 8'h02, 4'h0, 8'hEE);
    send_frame(8'h01, 8'h02, 8'h00);
    lat = 1;
    while (!tx_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("timeout_latency", lat, 18);
    wait_xfer(20);
    chk("timeout_err_pulses", err_cnt - err_before, 1);
    alu_mute = 1'b0;

    // out_valid on the 16th WAIT_RES cycle wins over the timeout.
    err_before = err_cnt;
    alu_delay  = 16;
    expect_frame(8'h03, 8'h04, 4'h0, 8'h07);
    send_frame(8'h03, 8'h04, 8'h00);
    wait_xfer(40);
    chk("edge_no_err", err_cnt - err_before, 0);
    alu_delay = 1;
`else
    // Without the timeout, a mute ALU keeps the FSM waiting.
    alu_mute = 1'b1;
    x_before = xfer_cnt;
    exp_alu_q.push_back({8'h01, 8'h02, 4'h0});
    send_frame(8'h01, 8'h02, 8'h00);
    idle_cycles(100);
    chk("no_tx_without_timeout", xfer_cnt - x_before, 0);
    chk("still_waiting", {fsm_state, tx_valid}, {3'd5, 1'b0});
    do_reset(1);
    alu_mute = 1'b0;
    chk("err_never", err_cnt, 0);
`endif

    idle_cycles(3);
    chk("alu_queue_empty", exp_alu_q.size(), 0);
    chk("tx_queue_empty", exp_tx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
